// File: rtl/dla_mov_gb2lb.sv
// GB-to-LB move engine: strided 2-D copy from the global buffer into the local buffer.
// Read side issues one GB request per granted cycle; write side retires returns in order.
module dla_mov_gb2lb #(
    parameter int unsigned DW     = 64,
    parameter int unsigned RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go_mov_gb2lb,
    input  logic [12:0]   stgr_gb2lb_gb_addr,
    input  logic [12:0]   stgr_gb2lb_gb_skip,
    input  logic [10:0]   stgr_gb2lb_lb_addr,
    input  logic [5:0]    stgr_gb2lb_lb_skip,
    input  logic [12:0]   stgr_gb2lb_len,
    input  logic [5:0]    stgr_gb2lb_iter,
    output logic          gb_rd_req,
    output logic [12:0]   gb_rd_addr,
    input  logic          gb_rd_gnt,
    input  logic          gb_rd_vld,
    input  logic [DW-1:0] gb_rd_data,
    output logic          lb_wr_en,
    output logic [10:0]   lb_wr_addr,
    output logic [DW-1:0] lb_wr_data,
    output logic          busy,
    output logic          done,
    output logic          go_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPT,
        S_RD,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t state, state_nx;

    logic [12:0] gb_skip;
    logic [12:0] len;
    logic [5:0]  iter;
    logic [5:0]  lb_skip;
    logic [19:0] total;
    logic [12:0] row_base;
    logic [12:0] col;
    logic [5:0]  row;
    logic [10:0] lb_ptr;
    logic [12:0] wr_col;
    logic [19:0] wr_cnt;
    logic [2:0]  flush_cnt;

    logic xfer;
    logic last_col;
    logic last_row;
    logic flush_done;
    logic wr_acc;

    assign xfer       = (state == S_RD) && gb_rd_gnt;
    assign last_col   = (col == len - 13'd1);
    assign last_row   = (row == iter - 6'd1);
    // Returns still in flight when reset hit are dropped until the read pipe has emptied.
    assign flush_done = (flush_cnt == 3'(RD_LAT));
    assign wr_acc     = gb_rd_vld && flush_done && ((state == S_RD) || (state == S_DRAIN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        busy      = (state != S_IDLE);
        done      = (state == S_FIN);
        gb_rd_req = (state == S_RD);
        case (state)
            S_IDLE:  if (go_mov_gb2lb) state_nx = S_CAPT;
            S_CAPT:  begin
                if ((stgr_gb2lb_len == 13'd0) || (stgr_gb2lb_iter == 6'd0)) state_nx = S_FIN;
                else                                                        state_nx = S_RD;
            end
            S_RD:    if (xfer && last_col && last_row) state_nx = S_DRAIN;
            S_DRAIN: if (wr_cnt == total) state_nx = S_FIN;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Read side: gb_rd_addr is kept equal to row_base + col.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gb_skip    <= '0;
            len        <= '0;
            iter       <= '0;
            lb_skip    <= '0;
            total      <= '0;
            row_base   <= '0;
            col        <= '0;
            row        <= '0;
            gb_rd_addr <= '0;
        end else if (state == S_CAPT) begin
            gb_skip    <= stgr_gb2lb_gb_skip;
            len        <= stgr_gb2lb_len;
            iter       <= stgr_gb2lb_iter;
            lb_skip    <= stgr_gb2lb_lb_skip;
            total      <= 20'(stgr_gb2lb_len) * 20'(stgr_gb2lb_iter);
            row_base   <= stgr_gb2lb_gb_addr;
            col        <= '0;
            row        <= '0;
            gb_rd_addr <= stgr_gb2lb_gb_addr;
        end else if (xfer) begin
            if (last_col) begin
                col        <= '0;
                row        <= row + 6'd1;
                row_base   <= row_base + gb_skip;
                gb_rd_addr <= row_base + gb_skip;
            end else begin
                col        <= col + 13'd1;
                gb_rd_addr <= gb_rd_addr + 13'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lb_wr_en   <= 1'b0;
            lb_wr_addr <= '0;
            lb_wr_data <= '0;
            lb_ptr     <= '0;
            wr_col     <= '0;
            wr_cnt     <= '0;
            flush_cnt  <= '0;
        end else begin
            lb_wr_en <= wr_acc;
            if (!flush_done) flush_cnt <= flush_cnt + 3'd1;
            if (state == S_CAPT) begin
                lb_ptr <= stgr_gb2lb_lb_addr;
                wr_col <= '0;
                wr_cnt <= '0;
            end else if (wr_acc) begin
                lb_wr_addr <= lb_ptr;
                lb_wr_data <= gb_rd_data;
                wr_cnt     <= wr_cnt + 20'd1;
                if (wr_col == len - 13'd1) begin
                    wr_col <= '0;
                    lb_ptr <= lb_ptr + 11'd1 + {5'd0, lb_skip};
                end else begin
                    wr_col <= wr_col + 13'd1;
                    lb_ptr <= lb_ptr + 11'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) go_err <= 1'b0;
        else     go_err <= go_mov_gb2lb && (state != S_IDLE);
    end

endmodule

// File: tb/tb_dla_mov_gb2lb.sv
// Bench for dla_mov_gb2lb: latency-accurate GB responder, queue-based reference model
// of the strided copy, and a per-cycle compare process.
module tb_dla_mov_gb2lb;

    localparam int unsigned DW     = 64;
    localparam int unsigned RD_LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          go_mov_gb2lb;
    logic [12:0]   stgr_gb2lb_gb_addr, stgr_gb2lb_gb_skip, stgr_gb2lb_len;
    logic [10:0]   stgr_gb2lb_lb_addr;
    logic [5:0]    stgr_gb2lb_lb_skip, stgr_gb2lb_iter;
    logic          gb_rd_req, gb_rd_gnt, gb_rd_vld;
    logic [12:0]   gb_rd_addr;
    logic [DW-1:0] gb_rd_data, lb_wr_data;
    logic          lb_wr_en, busy, done, go_err;
    logic [10:0]   lb_wr_addr;

    always #5 clk = ~clk;

    dla_mov_gb2lb #(.DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .go_mov_gb2lb(go_mov_gb2lb),
        .stgr_gb2lb_gb_addr(stgr_gb2lb_gb_addr), .stgr_gb2lb_gb_skip(stgr_gb2lb_gb_skip),
        .stgr_gb2lb_lb_addr(stgr_gb2lb_lb_addr), .stgr_gb2lb_lb_skip(stgr_gb2lb_lb_skip),
        .stgr_gb2lb_len(stgr_gb2lb_len), .stgr_gb2lb_iter(stgr_gb2lb_iter),
        .gb_rd_req(gb_rd_req), .gb_rd_addr(gb_rd_addr), .gb_rd_gnt(gb_rd_gnt),
        .gb_rd_vld(gb_rd_vld), .gb_rd_data(gb_rd_data),
        .lb_wr_en(lb_wr_en), .lb_wr_addr(lb_wr_addr), .lb_wr_data(lb_wr_data),
        .busy(busy), .done(done), .go_err(go_err)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [12:0]   exp_gb[$];
    logic [10:0]   exp_la[$];
    logic [63:0]   exp_ld[$];
    int            xfer_cyc[$];
    bit            run_on = 1'b0, degen = 1'b0, all_written = 1'b0, exp_goerr = 1'b0;
    int            start_c = 0, last_wr = 0, last_done_c = -1;
    bit            gnt_random = 1'b0;

    function automatic logic [63:0] mem_word(input logic [12:0] a);
        return {32'hC0DE_0000 + 32'(a), 32'(a) * 32'h9E37_79B1};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // GB responder: data returns exactly RD_LAT cycles after each transfer.
    initial begin
        logic        pv[0:RD_LAT];
        logic [12:0] pa[0:RD_LAT];
        for (int i = 0; i <= int'(RD_LAT); i++) begin pv[i] = 1'b0; pa[i] = '0; end
        gb_rd_gnt = 1'b0; gb_rd_vld = 1'b0; gb_rd_data = '0;
        forever begin
            @(posedge clk); #1;
            gb_rd_gnt = gnt_random ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int i = int'(RD_LAT); i > 0; i--) begin pv[i] = pv[i-1]; pa[i] = pa[i-1]; end
            pv[0] = gb_rd_req && gb_rd_gnt;
            pa[0] = gb_rd_addr;
            gb_rd_vld  = pv[RD_LAT];
            gb_rd_data = pv[RD_LAT] ? mem_word(pa[RD_LAT]) : '0;
        end
    end

    // Compare process
    initial begin
        forever begin
            bit eb, ed, er;
            int c;
            @(negedge clk);
            c = cyc;
            if (rst) begin
                exp_gb.delete(); exp_la.delete(); exp_ld.delete(); xfer_cyc.delete();
                run_on = 1'b0; exp_goerr = 1'b0;
            end else begin
                eb = run_on && (c >= start_c + 1);
                ed = run_on && (degen ? (c == start_c + 2) : (all_written && c == last_wr + 1));
                er = run_on && !degen && (c >= start_c + 2) && (exp_gb.size() > 0);
                check("busy", 64'(busy), 64'(eb));
                check("done", 64'(done), 64'(ed));
                check("go_err", 64'(go_err), 64'(exp_goerr));
                check("gb_rd_req", 64'(gb_rd_req), 64'(er));
                if (gb_rd_req && exp_gb.size() > 0) begin
                    check("gb_rd_addr", 64'(gb_rd_addr), 64'(exp_gb[0]));
                    if (gb_rd_gnt) begin
                        void'(exp_gb.pop_front());
                        xfer_cyc.push_back(c);
                    end
                end
                if (lb_wr_en) begin
                    if (exp_la.size() == 0) check("lb_wr_en extra", 64'(1), 64'(0));
                    else begin
                        check("lb_wr_addr", 64'(lb_wr_addr), 64'(exp_la.pop_front()));
                        check("lb_wr_data", lb_wr_data, exp_ld.pop_front());
                        if (xfer_cyc.size() > 0)
                            check("lb_wr latency", 64'(c), 64'(xfer_cyc.pop_front() + int'(RD_LAT) + 1));
                        else check("lb_wr before read", 64'(1), 64'(0));
                        if (exp_la.size() == 0) begin all_written = 1'b1; last_wr = c; end
                    end
                end
                exp_goerr = go_mov_gb2lb && eb;
                if (ed) begin run_on = 1'b0; last_done_c = c; end
                if (go_mov_gb2lb && !eb) begin
                    run_on = 1'b1; start_c = c; all_written = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_stg(input logic [12:0] g, gs, input logic [10:0] l, input logic [5:0] ls,
                           input logic [12:0] ln, input logic [5:0] it);
        stgr_gb2lb_gb_addr = g;  stgr_gb2lb_gb_skip = gs;
        stgr_gb2lb_lb_addr = l;  stgr_gb2lb_lb_skip = ls;
        stgr_gb2lb_len     = ln; stgr_gb2lb_iter    = it;
    endtask

    task automatic scramble();
        set_stg(13'($urandom), 13'($urandom), 11'($urandom), 6'($urandom),
                13'($urandom), 6'($urandom));
    endtask

    // Loads the expected copy into the model, pulses go, returns the go cycle.
    task automatic launch(input logic [12:0] g, gs, input logic [10:0] l, input logic [5:0] ls,
                          input logic [12:0] ln, input logic [5:0] it, output int n);
        for (int r = 0; r < int'(it); r++)
            for (int k = 0; k < int'(ln); k++) begin
                logic [12:0] ga;
                ga = 13'(int'(g) + r * int'(gs) + k);
                exp_gb.push_back(ga);
                exp_la.push_back(11'(int'(l) + r * (int'(ln) + int'(ls)) + k));
                exp_ld.push_back(mem_word(ga));
            end
        degen = (ln == 13'd0) || (it == 6'd0);
        scramble();
        go_mov_gb2lb = 1'b1;
        n = cyc;
        tick();
        go_mov_gb2lb = 1'b0;
        set_stg(g, gs, l, ls, ln, it);
        tick();
        scramble();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (run_on && k < budget) begin tick(); k++; end
        check({name, " timeout"}, 64'(run_on), 64'(0));
        check({name, " leftover"}, 64'(exp_gb.size() + exp_la.size()), 64'(0));
    endtask

    task automatic check_zero(input string name);
        check({name, " gb_rd_req"}, 64'(gb_rd_req), 64'(0));
        check({name, " gb_rd_addr"}, 64'(gb_rd_addr), 64'(0));
        check({name, " lb_wr_en"}, 64'(lb_wr_en), 64'(0));
        check({name, " lb_wr_addr"}, 64'(lb_wr_addr), 64'(0));
        check({name, " lb_wr_data"}, lb_wr_data, 64'(0));
        check({name, " busy"}, 64'(busy), 64'(0));
        check({name, " done"}, 64'(done), 64'(0));
        check({name, " go_err"}, 64'(go_err), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        go_mov_gb2lb = 1'b0;
        set_stg('0, '0, '0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(posedge clk); #2; rst = 1'b0;
        tick();

        // Single row
        launch(13'h010, 13'h000, 11'h020, 6'd0, 13'd4, 6'd1, n);
        check("t1 first req", 64'(gb_rd_req), 64'(1));
        check("t1 first addr", 64'(gb_rd_addr), 64'h010);
        check("t1 model last lb", 64'(exp_la[3]), 64'h023);
        wait_idle("t1", 50);
        check("t1 done cycle", 64'(last_done_c), 64'(n + 9));

        // 2-D strides
        launch(13'h100, 13'h040, 11'h000, 6'd2, 13'd3, 6'd3, n);
        check("t2 model gb[3]", 64'(exp_gb[3]), 64'h140);
        check("t2 model gb[8]", 64'(exp_gb[8]), 64'h182);
        check("t2 model lb[3]", 64'(exp_la[3]), 64'd5);
        check("t2 model lb[8]", 64'(exp_la[8]), 64'd12);
        wait_idle("t2", 60);
        check("t2 done cycle", 64'(last_done_c), 64'(n + 14));

        // Grant stalls
        gnt_random = 1'b1;
        launch(13'h300, 13'h020, 11'h100, 6'd3, 13'd8, 6'd2, n);
        wait_idle("t3", 400);
        gnt_random = 1'b0;
        tick();

        // Degenerate runs
        launch(13'h050, 13'h010, 11'h040, 6'd1, 13'd0, 6'd5, n);
        wait_idle("t4a", 10);
        check("t4a done cycle", 64'(last_done_c), 64'(n + 2));
        tick();
        launch(13'h050, 13'h010, 11'h040, 6'd1, 13'd5, 6'd0, n);
        wait_idle("t4b", 10);
        check("t4b done cycle", 64'(last_done_c), 64'(n + 2));
        tick();

        // go while busy
        launch(13'h400, 13'h008, 11'h200, 6'd4, 13'd6, 6'd2, n);
        repeat (3) tick();
        go_mov_gb2lb = 1'b1;
        scramble();
        tick();
        go_mov_gb2lb = 1'b0;
        check("t5 go_err pulse", 64'(go_err), 64'(1));
        wait_idle("t5", 60);
        check("t5 done cycle", 64'(last_done_c), 64'(n + 17));
        tick();

        // Address wrap
        launch(13'h1FFE, 13'h000, 11'h7FF, 6'd0, 13'd4, 6'd1, n);
        check("t6 model gb[2]", 64'(exp_gb[2]), 64'h000);
        check("t6 model lb[1]", 64'(exp_la[1]), 64'h000);
        wait_idle("t6", 50);
        tick();

        // Reset mid-RD, then a clean run
        launch(13'h200, 13'h080, 11'h300, 6'd0, 13'd100, 6'd1, n);
        repeat (20) tick();
        @(posedge clk); #2; rst = 1'b1;
        #1;
        check_zero("mid reset");
        @(posedge clk);
        @(posedge clk); #2; rst = 1'b0;
        tick();
        launch(13'h020, 13'h010, 11'h010, 6'd1, 13'd3, 6'd2, n);
        wait_idle("t7", 60);
        check("t7 done cycle", 64'(last_done_c), 64'(n + 11));
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
